itag_ctrl: RTL

Sequencing controller for the instruction-cache tag RAM (itag).
- Owns the tag RAM single address port.
- Invalidates all lines after reset or on flush.
- Performs lookup compare on fetch requests and runs a miss/linefill handshake.
- Writes the new tag when the linefill completes.
- Sits between the fetch unit, the itag instance and the linefill/bus interface.

---
 rtl/itag_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/itag_ctrl.sv
// itag_ctrl: sequencing controller for the instruction-cache tag RAM.
// This block owns the single tag RAM address port. It walks an invalidate
// sweep after reset or a flush. It then serves fetch lookups and runs a
// miss/linefill handshake, writing the new tag once the line fill completes.
// Optional build macro ITAG_CTRL_STATS_EN adds saturating hit/miss counters.
module itag_ctrl #(
  parameter int NL  = 128,
  parameter int LSS = 7,
  parameter int LSH = LSS + 4,
  parameter int PSL = LSH + 1,
  parameter int TS  = 2 + (32 - PSL)
) (
  input  logic           nGCLK,
  input  logic           nRESET,
  input  logic           req,
  input  logic [31:0]    req_addr,
  input  logic           flush,
  output logic           req_rdy,
  output logic           hit,
  output logic           fill_req,
  output logic [31:0]    fill_addr,
  input  logic           fill_done,
  output logic           flush_busy,
  output logic [LSS-1:0] tag_addr,
  output logic [TS-1:0]  tag_wdata,
  output logic           tag_we,
  input  logic [TS-1:0]  tag_rdata
`ifdef ITAG_CTRL_STATS_EN
  ,
  output logic [15:0]    hit_cnt,
  output logic [15:0]    miss_cnt
`endif
);

  // Lowest address bit of the line index (bit 5 with the default geometry).
  localparam int LSL = LSH - LSS + 1;

  typedef enum logic [2:0] {
    ST_FLUSH  = 3'd0,
    ST_IDLE   = 3'd1,
    ST_LOOKUP = 3'd2,
    ST_FILL   = 3'd3,
    ST_UPDATE = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [LSS-1:0] idx_q, idx_d;
  logic           flush_pend_q, flush_pend_d;
  logic [31:0]    addr_q, addr_d;
  logic           match_s;
  logic           unused_s;

  // Valid bit set and stored page tag equal to the latched request; D bit is ignored.
  assign match_s   = tag_rdata[TS-2] && (tag_rdata[TS-3:0] == addr_q[31:PSL]);
  assign fill_addr = {addr_q[31:LSL], {LSL{1'b0}}};
  // Byte offset of the latched address and the tag D bit play no part in control.
  assign unused_s  = ^{addr_q[LSL-1:0], tag_rdata[TS-1]};

  // State, walk index, pending-flush flag and latched request address.
  always_ff @(posedge nGCLK) begin
    if (!nRESET) begin
      state_q      <= ST_FLUSH;
      idx_q        <= {LSS{1'b0}};
      flush_pend_q <= 1'b0;
      addr_q       <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      flush_pend_q <= flush_pend_d;
      addr_q       <= addr_d;
    end
  end

  // Next-state and output decode; tag writes are suppressed while reset is held.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    flush_pend_d = flush_pend_q;
    addr_d       = addr_q;
    req_rdy      = 1'b0;
    hit          = 1'b0;
    fill_req     = 1'b0;
    flush_busy   = 1'b0;
    tag_addr     = addr_q[LSH:LSL];
    tag_wdata    = {TS{1'b0}};
    tag_we       = 1'b0;
    case (state_q)
      ST_FLUSH: begin
        flush_busy = 1'b1;
        tag_addr   = idx_q;
        tag_we     = nRESET;
        idx_d      = idx_q + LSS'(1);
        if (idx_q == LSS'(NL - 1)) begin
          state_d      = ST_IDLE;
          flush_pend_d = 1'b0;
        end else begin
          state_d = ST_FLUSH;
        end
      end
      ST_IDLE: begin
        req_rdy = 1'b1;
        if (flush || flush_pend_q) begin
          state_d = ST_FLUSH;
          idx_d   = {LSS{1'b0}};
        end else if (req) begin
          addr_d   = req_addr;
          tag_addr = req_addr[LSH:LSL];
          state_d  = ST_LOOKUP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOOKUP: begin
        if (match_s) begin
          hit     = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        fill_req = 1'b1;
        if (flush) begin
          flush_pend_d = 1'b1;
        end else begin
          flush_pend_d = flush_pend_q;
        end
        if (fill_done) begin
          state_d = ST_UPDATE;
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_UPDATE: begin
        tag_wdata = {1'b0, 1'b1, addr_q[31:PSL]};
        tag_we    = nRESET;
        hit       = 1'b1;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_FLUSH;
        idx_d   = {LSS{1'b0}};
      end
    endcase
  end

`ifdef ITAG_CTRL_STATS_EN
  logic [15:0] hit_cnt_q, miss_cnt_q;

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;

  // Saturating lookup statistics, cleared on the first cycle of every invalidate walk.
  always_ff @(posedge nGCLK) begin
    if (!nRESET) begin
      hit_cnt_q  <= 16'd0;
      miss_cnt_q <= 16'd0;
    end else if ((state_q == ST_FLUSH) && (idx_q == {LSS{1'b0}})) begin
      hit_cnt_q  <= 16'd0;
      miss_cnt_q <= 16'd0;
    end else if (state_q == ST_LOOKUP) begin
      if (match_s) begin
        if (hit_cnt_q != 16'hFFFF) begin
          hit_cnt_q <= hit_cnt_q + 16'd1;
        end else begin
          hit_cnt_q <= hit_cnt_q;
        end
      end else begin
        if (miss_cnt_q != 16'hFFFF) begin
          miss_cnt_q <= miss_cnt_q + 16'd1;
        end else begin
          miss_cnt_q <= miss_cnt_q;
        end
      end
    end else begin
      hit_cnt_q  <= hit_cnt_q;
      miss_cnt_q <= miss_cnt_q;
    end
  end
`endif

endmodule
